// File: rtl/riscv_stage_checker.sv
// Self-check monitor for a RISC-V pipeline stage: queues expected per-instruction
// field values and compares them, under a per-entry channel mask, against stage outputs.
module riscv_stage_checker #(
    parameter int NUM_CH      = 6,
    parameter int CH_WIDTH    = 64,
    parameter int DEPTH       = 8,
    parameter int CNT_WIDTH   = 16,
    parameter int STOP_ON_ERR = 0
) (
    input  logic                       i_riscv_clk,
    input  logic                       i_riscv_rst,
    input  logic                       i_riscv_chk_en,
    input  logic                       i_riscv_chk_exp_valid,
    output logic                       o_riscv_chk_exp_ready,
    input  logic [NUM_CH*CH_WIDTH-1:0] i_riscv_chk_exp_data,
    input  logic [NUM_CH-1:0]          i_riscv_chk_exp_mask,
    input  logic                       i_riscv_chk_obs_valid,
    input  logic [NUM_CH*CH_WIDTH-1:0] i_riscv_chk_obs_data,
    output logic                       o_riscv_chk_err,
    output logic [NUM_CH-1:0]          o_riscv_chk_err_ch,
    output logic [CNT_WIDTH-1:0]       o_riscv_chk_err_idx,
    output logic [CNT_WIDTH-1:0]       o_riscv_chk_pass_cnt,
    output logic [CNT_WIDTH-1:0]       o_riscv_chk_fail_cnt,
    output logic                       o_riscv_chk_underflow,
    output logic                       o_riscv_chk_halted
);
    // state | meaning
    // IDLE  | comparisons disabled, observations ignored
    // RUN   | every valid observation is compared against the queue head
    // HALT  | frozen after a failure (STOP_ON_ERR only), left when en drops
    localparam int DW = NUM_CH * CH_WIDTH;
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]          FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    state_t                state, state_next;
    logic [DW-1:0]         mem_data [DEPTH];
    logic [NUM_CH-1:0]     mem_mask [DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [AW:0]           count;
    logic [CNT_WIDTH-1:0]  idx, idx_next;
    logic                  empty, push, pop, cmp_ev, ev_fail;
    logic [NUM_CH-1:0]     fail_vec;

    assign empty                 = (count == '0);
    assign o_riscv_chk_exp_ready = (count != FULL_CNT);
    assign push                  = i_riscv_chk_exp_valid && o_riscv_chk_exp_ready;
    assign cmp_ev                = (state == RUN) && i_riscv_chk_obs_valid;
    assign pop                   = cmp_ev && !empty;
    assign ev_fail               = cmp_ev && (empty || (fail_vec != '0));
    assign idx_next              = (idx == CNT_MAX) ? idx : idx + CNT_ONE;
    assign o_riscv_chk_halted    = (state == HALT);

    always_comb begin
        fail_vec = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            fail_vec[k] = mem_mask[rd_ptr][k] &&
                (i_riscv_chk_obs_data[k*CH_WIDTH +: CH_WIDTH] != mem_data[rd_ptr][k*CH_WIDTH +: CH_WIDTH]);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_riscv_chk_en) state_next = RUN;
            RUN: begin
                if (!i_riscv_chk_en)                    state_next = IDLE;
                else if (ev_fail && (STOP_ON_ERR != 0)) state_next = HALT;
            end
            HALT:    if (!i_riscv_chk_en) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Storage needs no reset: the pointers and count define which entries are live.
    always_ff @(posedge i_riscv_clk) begin
        if (push) begin
            mem_data[wr_ptr] <= i_riscv_chk_exp_data;
            mem_mask[wr_ptr] <= i_riscv_chk_exp_mask;
        end
    end

    always_ff @(posedge i_riscv_clk) begin
        if (i_riscv_rst) begin
            state                 <= IDLE;
            wr_ptr                <= '0;
            rd_ptr                <= '0;
            count                 <= '0;
            idx                   <= '0;
            o_riscv_chk_err       <= 1'b0;
            o_riscv_chk_err_ch    <= '0;
            o_riscv_chk_err_idx   <= '0;
            o_riscv_chk_pass_cnt  <= '0;
            o_riscv_chk_fail_cnt  <= '0;
            o_riscv_chk_underflow <= 1'b0;
        end else begin
            state           <= state_next;
            o_riscv_chk_err <= ev_fail;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            if (cmp_ev) idx <= idx_next;
            if (ev_fail) begin
                o_riscv_chk_err_ch  <= empty ? '1 : fail_vec;
                o_riscv_chk_err_idx <= idx_next;
                if (o_riscv_chk_fail_cnt != CNT_MAX)
                    o_riscv_chk_fail_cnt <= o_riscv_chk_fail_cnt + CNT_ONE;
            end else if (cmp_ev && (o_riscv_chk_pass_cnt != CNT_MAX)) begin
                o_riscv_chk_pass_cnt <= o_riscv_chk_pass_cnt + CNT_ONE;
            end
            if (cmp_ev && empty) o_riscv_chk_underflow <= 1'b1;
        end
    end

endmodule
